// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 160x120 frame store sequencer.
// Streams pixels into the back bank and swaps banks at vblank once full.
module frame_buffer_ctrl #(
  parameter int X_ADDRW_SCALED  = 8,
  parameter int Y_ADDRW_SCALED  = 7,
  parameter int H_PIXELS_SCALED = 160,
  parameter int V_PIXELS_SCALED = 120
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  input  logic                      pix_data,
  output logic                      pix_ready,
  input  logic                      vga_frame_end,
  output logic                      write_enable,
  output logic [X_ADDRW_SCALED-1:0] mem_x_pos,
  output logic [Y_ADDRW_SCALED-1:0] mem_y_pos,
  output logic                      wr_data,
  output logic                      video_bank_sel,
  output logic                      sync_err,
  output logic [7:0]                repeat_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } state_t;

  localparam logic [X_ADDRW_SCALED-1:0] X_LAST =
    X_ADDRW_SCALED'(H_PIXELS_SCALED - 1);
  localparam logic [Y_ADDRW_SCALED-1:0] Y_LAST =
    Y_ADDRW_SCALED'(V_PIXELS_SCALED - 1);
  localparam logic [X_ADDRW_SCALED-1:0] X_ONE =
    X_ADDRW_SCALED'(1);

  state_t                    state;
  logic [X_ADDRW_SCALED-1:0] x_cnt;
  logic [Y_ADDRW_SCALED-1:0] y_cnt;
  logic                      accept;

  // Ready depends on state only, so the source never sees a loop
  assign pix_ready = (state != FULL);
  assign accept    = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      video_bank_sel <= 1'b0;
      write_enable   <= 1'b0;
      mem_x_pos      <= '0;
      mem_y_pos      <= '0;
      wr_data        <= 1'b0;
      sync_err       <= 1'b0;
      repeat_count   <= 8'd0;
      x_cnt          <= '0;
      y_cnt          <= '0;
    end else begin
      write_enable <= 1'b0;
      sync_err     <= 1'b0;
      if (vga_frame_end && state != FULL &&
          repeat_count != 8'hff)
        repeat_count <= repeat_count + 8'd1;
      unique case (state)
        IDLE: begin
          if (accept && pix_sof) begin
            write_enable <= 1'b1;
            wr_data      <= pix_data;
            mem_x_pos    <= '0;
            mem_y_pos    <= '0;
            x_cnt        <= X_ONE;
            y_cnt        <= '0;
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            write_enable <= 1'b1;
            wr_data      <= pix_data;
            if (pix_sof) begin
              // Early SOF restarts the frame from (0,0)
              mem_x_pos <= '0;
              mem_y_pos <= '0;
              x_cnt     <= X_ONE;
              y_cnt     <= '0;
              sync_err  <= 1'b1;
            end else begin
              mem_x_pos <= x_cnt;
              mem_y_pos <= y_cnt;
              if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                if (y_cnt == Y_LAST) begin
                  y_cnt <= '0;
                  state <= FULL;
                end else begin
                  y_cnt <= y_cnt + 1'b1;
                end
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (vga_frame_end) begin
            video_bank_sel <= ~video_bank_sel;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl.
// Expected writes are queued at acceptance and popped per cycle.
module tb_frame_buffer_ctrl;

  logic       clk;
  logic       reset;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_data;
  logic       pix_ready;
  logic       vga_frame_end;
  logic       write_enable;
  logic [7:0] mem_x_pos;
  logic [6:0] mem_y_pos;
  logic       wr_data;
  logic       video_bank_sel;
  logic       sync_err;
  logic [7:0] repeat_count;

  frame_buffer_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .pix_sof        (pix_sof),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .vga_frame_end  (vga_frame_end),
    .write_enable   (write_enable),
    .mem_x_pos      (mem_x_pos),
    .mem_y_pos      (mem_y_pos),
    .wr_data        (wr_data),
    .video_bank_sel (video_bank_sel),
    .sync_err       (sync_err),
    .repeat_count   (repeat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;
  int n_sync = 0;

  logic [15:0] q[$];

  // Reference model state
  int   m_st;
  int   m_x;
  int   m_y;
  int   m_rc;
  logic m_bank;
  logic m_sync;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (write_enable === 1'b1) n_we++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("we", 32'(write_enable), 32'd1);
      if (write_enable === 1'b1)
        check("waddr",
              32'({mem_x_pos, mem_y_pos, wr_data}),
              32'(e));
    end else begin
      check("no_we", 32'(write_enable), 32'd0);
    end
  end

  task automatic model_reset();
    m_st   = 0;
    m_x    = 0;
    m_y    = 0;
    m_rc   = 0;
    m_bank = 1'b0;
    m_sync = 1'b0;
  endtask

  task automatic beat(input logic sof,
                      input logic v,
                      input logic vfe);
    logic d;
    logic acc;
    d             = 1'($urandom);
    pix_valid     = v;
    pix_sof       = sof;
    pix_data      = d;
    vga_frame_end = vfe;
    check("ready", 32'(pix_ready), 32'(m_st != 2));
    acc = v && (m_st != 2);
    @(posedge clk);
    m_sync = 1'b0;
    if (m_st == 2) begin
      if (vfe) begin
        m_bank = ~m_bank;
        m_st   = 0;
      end
    end else begin
      if (vfe && m_rc != 255) m_rc++;
      if (acc && sof) begin
        q.push_back({8'd0, 7'd0, d});
        m_sync = (m_st == 1);
        m_x    = 1;
        m_y    = 0;
        m_st   = 1;
      end else if (acc && m_st == 1) begin
        q.push_back({8'(m_x), 7'(m_y), d});
        if (m_x == 159) begin
          m_x = 0;
          if (m_y == 119) begin
            m_y  = 0;
            m_st = 2;
          end else begin
            m_y++;
          end
        end else begin
          m_x++;
        end
      end
    end
    #1;
    pix_valid     = 1'b0;
    pix_sof       = 1'b0;
    vga_frame_end = 1'b0;
    if (sync_err === 1'b1) n_sync++;
    check("bank", 32'(video_bank_sel), 32'(m_bank));
    check("rcount", 32'(repeat_count), 32'(m_rc));
    check("sync", 32'(sync_err), 32'(m_sync));
  endtask

  // n valid non-SOF beats, optionally with random idle gaps
  task automatic send_beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) beat(1'b0, 1'b0, 1'b0);
      end
      beat(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    vga_frame_end = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_bank", 32'(video_bank_sel), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
    check("rst_rcount", 32'(repeat_count), 32'd0);
    check("rst_sync", 32'(sync_err), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int we0;
    reset         = 1'b1;
    pix_valid     = 1'b0;
    pix_sof       = 1'b0;
    pix_data      = 1'b0;
    vga_frame_end = 1'b0;
    model_reset();
    do_reset();

    // Garbage before SOF must be dropped
    send_beats(10, 1'b0);

    // Continuous full frame
    we0 = n_we;
    beat(1'b1, 1'b1, 1'b0);
    send_beats(19199, 1'b0);
    check("ready_full", 32'(pix_ready), 32'd0);
    beat(1'b0, 1'b0, 1'b0);
    check("frame_writes", 32'(n_we - we0), 32'd19200);
    beat(1'b0, 1'b0, 1'b1);
    check("swap1", 32'(video_bank_sel), 32'd1);
    check("ready_idle", 32'(pix_ready), 32'd1);

    // Early SOF, vblanks mid-frame, last beat on vblank
    n_sync = 0;
    beat(1'b1, 1'b1, 1'b0);
    send_beats(500, 1'b1);
    beat(1'b1, 1'b1, 1'b0);
    check("sync_once", 32'(n_sync), 32'd1);
    send_beats(3000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b0);
    end
    check("rcount3", 32'(repeat_count), 32'd3);
    check("noswap", 32'(video_bank_sel), 32'd1);
    send_beats(19199 - 3000 - 1, 1'b1);
    check("ready_pre", 32'(pix_ready), 32'd1);
    beat(1'b0, 1'b1, 1'b1);
    check("rcount4", 32'(repeat_count), 32'd4);
    check("noswap_last", 32'(video_bank_sel), 32'd1);
    check("ready_last", 32'(pix_ready), 32'd0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    check("swap2", 32'(video_bank_sel), 32'd0);
    check("sync_total", 32'(n_sync), 32'd1);

    // Saturation of repeat_count
    for (int i = 0; i < 300; i++) begin
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b0);
    end
    check("rcount_sat", 32'(repeat_count), 32'd255);

    // Reset mid-frame with counters at (37,5)
    beat(1'b1, 1'b1, 1'b0);
    send_beats(836, 1'b0);
    check("pre_rst_x", 32'(m_x), 32'd37);
    do_reset();
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    send_beats(5, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0);
    check("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
